exp_controller: RTL and testbench
=================================

Name: exp_controller

Overview:
- Control FSM for the Taylor-series e^x datapath.
- Accepts a start request and sequences the datapath's register, counter, mux and accumulator control lines.
- Iterates one series term per loop until the datapath's term counter reports carry-out, then reports completion.
- Sits beside the datapath in the integrated top level; its outputs connect 1:1 to the datapath control inputs, and it consumes the datapath `co`.

Parameters:
- WAIT_RELEASE, 1, 1 = run begins only after `start` is seen high then low (push-button style); 0 = run begins on the cycle after `start` is sampled high.
- DONE_PULSE, 0, 0 = `done` held high until the next accepted start; 1 = `done` high for exactly one cycle.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  run request
- co  input  1  datapath term-counter carry-out (high while counter is at its final address)
- zx, initx, ldx  output  1 each  x register zero / init / load
- zt, initt, ldt  output  1 each  temp register zero / init / load
- zr, initr, ldr  output  1 each  result register zero / init / load
- zc, ldc, enc  output  1 each  term counter zero / load / count-enable
- s  output  1  mux select: 0 = x register, 1 = LUT coefficient
- ready  output  1  high in IDLE; a start is accepted only here
- done  output  1  result valid

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are Moore, decoded from registered state only; no output depends combinationally on `start` or `co`.
- Reset: state = IDLE; ready = 1; done = 0; every datapath control = 0. Reset mid-run takes effect at the next edge, abandoning the run with no further loads.
- States:
  - IDLE: ready = 1. On start = 1, go to REL if WAIT_RELEASE = 1, else LOAD.
  - REL: waits for start = 0, then goes to LOAD.
  - LOAD: ldx = 1, initt = 1, initr = 1, zc = 1, for one cycle; then MUL_X.
  - MUL_X: s = 0, ldt = 1 (temp ← temp·x); then MUL_C.
  - MUL_C: s = 1, ldt = 1 (temp ← temp·coef[adr]); then ACC.
  - ACC: ldr = 1 (result ← result + temp), enc = 1. If co = 1 in this cycle, go to DONE; else go to MUL_X.
  - DONE: done = 1, ready = 1. A start here is accepted exactly as in IDLE; done drops when the run is accepted.
    - DONE_PULSE = 1: DONE lasts one cycle, then IDLE.
    - DONE_PULSE = 0: DONE persists until a start is accepted.
- Only one of ldt or ldr is high in any cycle. s is 0 in every state except MUL_C.
- Latency with WAIT_RELEASE = 0 and a 16-address counter:
  - 1 (IDLE→LOAD) + 1 (LOAD) + 16×3 (terms) = 50 cycles from the start sample edge to done high.
  - The final ACC runs with co = 1, so the last coefficient is included.
- start is ignored in LOAD, MUL_X, MUL_C and ACC. co is ignored outside ACC.
- A start held high through DONE with WAIT_RELEASE = 1 re-enters REL; no second run occurs until release.

Optional Feature:
- Macro: EXP_CTRL_ABORT_EN.
- With it: adds input `abort` (1 bit). abort = 1 in any state other than IDLE/DONE forces the next state to IDLE and asserts zr for that one cycle. result is therefore 0 and done stays 0. abort has priority over every transition except rst.
- Without it: no abort port, and the FSM is exactly as described above.

Decomposition:
- Shared package exp_pkg holds the state enum type exp_state_t (IDLE, REL, LOAD, MUL_X, MUL_C, ACC, DONE).
- A packed struct exp_ctrl_t bundles the 13 datapath control bits so the top level and the datapath share one definition.
- No sub-module: one next-state block and one output-decode block within exp_controller.

Test Plan:
- Reset mid-run: rst = 1 for 1 cycle while in MUL_C → next cycle state IDLE, ready = 1, all controls 0, done = 0.
- Nominal run (WAIT_RELEASE = 0), counter stub asserting co on the 16th ACC → LOAD once; exact MUL_X/MUL_C/ACC pattern ×16; done rises 50 cycles after start sampled; enc pulsed 16 times, ldr 16 times, ldt 32 times.
- Button mode (WAIT_RELEASE = 1): start high for 5 cycles then low → LOAD occurs the cycle after release, never while start is high; start held high through DONE → no rerun until release.
- Early co (co = 1 on the 3rd ACC) → DONE after 3 terms; total 11 cycles from start sample; no further ldt.
- DONE_PULSE = 1 → done high exactly 1 cycle, then ready = 1, done = 0. DONE_PULSE = 0 → done held 100 cycles until a new start, then falls as LOAD begins.
- With EXP_CTRL_ABORT_EN: abort during term 7 MUL_X → next cycle zr = 1 and IDLE; done never asserts. A following start runs a full 50-cycle sequence correctly.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared types for the e^x series controller and its datapath: FSM state
// encoding and the 13-bit datapath control bundle.
package exp_pkg;

  localparam int unsigned EXP_STATE_W = 3;
  localparam int unsigned EXP_CTRL_W  = 13;

  typedef enum logic [EXP_STATE_W-1:0] {
    IDLE  = 3'd0,
    REL   = 3'd1,
    LOAD  = 3'd2,
    MUL_X = 3'd3,
    MUL_C = 3'd4,
    ACC   = 3'd5,
    DONE  = 3'd6
  } exp_state_t;

  typedef struct packed {
    logic zx;
    logic initx;
    logic ldx;
    logic zt;
    logic initt;
    logic ldt;
    logic zr;
    logic initr;
    logic ldr;
    logic zc;
    logic ldc;
    logic enc;
    logic s;
  } exp_ctrl_t;

  // Datapath control lines asserted in each state.
  function automatic exp_ctrl_t exp_ctrl_decode(input exp_state_t st);
    exp_ctrl_t c;
    c = '0;
    case (st)
      LOAD: begin
        c.ldx   = 1'b1;
        c.initt = 1'b1;
        c.initr = 1'b1;
        c.zc    = 1'b1;
      end
      MUL_X: c.ldt = 1'b1;
      MUL_C: begin
        c.ldt = 1'b1;
        c.s   = 1'b1;
      end
      ACC: begin
        c.ldr = 1'b1;
        c.enc = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exp_controller.sv
// Control FSM for the Taylor-series e^x datapath; one term per MUL_X/MUL_C/ACC loop.
// Optional abort input enabled by defining EXP_CTRL_ABORT_EN.
module exp_controller
  import exp_pkg::*;
#(
  parameter bit WAIT_RELEASE = 1'b1,
  parameter bit DONE_PULSE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic co,
`ifdef EXP_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic zx,
  output logic initx,
  output logic ldx,
  output logic zt,
  output logic initt,
  output logic ldt,
  output logic zr,
  output logic initr,
  output logic ldr,
  output logic zc,
  output logic ldc,
  output logic enc,
  output logic s,
  output logic ready,
  output logic done
);

  exp_state_t state_q, state_d;
  exp_ctrl_t  ctrl_q, ctrl_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       abort_hit;

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_d   = state_q;
    abort_hit = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (WAIT_RELEASE) state_d = REL;
          else              state_d = LOAD;
        end else if ((state_q == DONE) && DONE_PULSE) begin
          state_d = IDLE;
        end
      end
      REL:     if (!start) state_d = LOAD;
      LOAD:    state_d = MUL_X;
      MUL_X:   state_d = MUL_C;
      MUL_C:   state_d = ACC;
      ACC: begin
        if (co) state_d = DONE;
        else    state_d = MUL_X;
      end
      default: state_d = IDLE;
    endcase
`ifdef EXP_CTRL_ABORT_EN
    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d   = IDLE;
      abort_hit = 1'b1;
    end
`endif
  end

  // Output decode from the next state so the registered outputs track state_q exactly.
  always_comb begin
    ctrl_d    = exp_ctrl_decode(state_d);
    ctrl_d.zr = abort_hit;
    ready_d   = (state_d == IDLE) || (state_d == DONE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign zx    = ctrl_q.zx;
  assign initx = ctrl_q.initx;
  assign ldx   = ctrl_q.ldx;
  assign zt    = ctrl_q.zt;
  assign initt = ctrl_q.initt;
  assign ldt   = ctrl_q.ldt;
  assign zr    = ctrl_q.zr;
  assign initr = ctrl_q.initr;
  assign ldr   = ctrl_q.ldr;
  assign zc    = ctrl_q.zc;
  assign ldc   = ctrl_q.ldc;
  assign enc   = ctrl_q.enc;
  assign s     = ctrl_q.s;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_exp_controller.sv
// Directed bench for exp_controller: instance a (WAIT_RELEASE=0, DONE_PULSE=0)
// and instance b (WAIT_RELEASE=1, DONE_PULSE=1), each with a term-counter stub.
`timescale 1ns/1ps
module tb_exp_controller;
  import exp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, co_a, rst_b, start_b, co_b;
`ifdef EXP_CTRL_ABORT_EN
  logic abort_a, abort_b;
`endif
  logic zx_a, initx_a, ldx_a, zt_a, initt_a, ldt_a, zr_a, initr_a, ldr_a, zc_a, ldc_a, enc_a, s_a;
  logic zx_b, initx_b, ldx_b, zt_b, initt_b, ldt_b, zr_b, initr_b, ldr_b, zc_b, ldc_b, enc_b, s_b;
  logic ready_a, done_a, ready_b, done_b;
  exp_ctrl_t ca, cb;

  assign ca = {zx_a, initx_a, ldx_a, zt_a, initt_a, ldt_a, zr_a, initr_a, ldr_a, zc_a, ldc_a, enc_a, s_a};
  assign cb = {zx_b, initx_b, ldx_b, zt_b, initt_b, ldt_b, zr_b, initr_b, ldr_b, zc_b, ldc_b, enc_b, s_b};

  exp_controller #(.WAIT_RELEASE(1'b0), .DONE_PULSE(1'b0)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .co(co_a),
`ifdef EXP_CTRL_ABORT_EN
    .abort(abort_a),
`endif
    .zx(zx_a), .initx(initx_a), .ldx(ldx_a), .zt(zt_a), .initt(initt_a), .ldt(ldt_a),
    .zr(zr_a), .initr(initr_a), .ldr(ldr_a), .zc(zc_a), .ldc(ldc_a), .enc(enc_a), .s(s_a),
    .ready(ready_a), .done(done_a)
  );

  exp_controller #(.WAIT_RELEASE(1'b1), .DONE_PULSE(1'b1)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .co(co_b),
`ifdef EXP_CTRL_ABORT_EN
    .abort(abort_b),
`endif
    .zx(zx_b), .initx(initx_b), .ldx(ldx_b), .zt(zt_b), .initt(initt_b), .ldt(ldt_b),
    .zr(zr_b), .initr(initr_b), .ldr(ldr_b), .zc(zc_b), .ldc(ldc_b), .enc(enc_b), .s(s_b),
    .ready(ready_b), .done(done_b)
  );

  // Term-counter stubs: cleared by zc, advanced by enc, co at the final address.
  int cnt_a = 0, cnt_b = 0, last_a = 15, last_b = 15;
  always_ff @(posedge clk) begin
    if (zc_a) cnt_a <= 0; else if (enc_a) cnt_a <= cnt_a + 1;
    if (zc_b) cnt_b <= 0; else if (enc_b) cnt_b <= cnt_b + 1;
  end
  assign co_a = (cnt_a == last_a);
  assign co_b = (cnt_b == last_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected controls n cycles after LOAD: LOAD, then MUL_X / MUL_C / ACC repeating.
  function automatic exp_ctrl_t exp_ctrl(input int n);
    exp_ctrl_t c;
    c = '0;
    if (n == 0) begin
      c.ldx = 1'b1; c.initt = 1'b1; c.initr = 1'b1; c.zc = 1'b1;
    end else begin
      case ((n - 1) % 3)
        0:       c.ldt = 1'b1;
        1:       begin c.ldt = 1'b1; c.s = 1'b1; end
        default: begin c.ldr = 1'b1; c.enc = 1'b1; end
      endcase
    end
    return c;
  endfunction

  // Called in the LOAD cycle; follows the run to done and checks pattern, counts, latency.
  task automatic run_monitor(input bit use_b, input int terms, input string tag);
    int n = 0, bad = 0, n_ldt = 0, n_ldr = 0, n_enc = 0, n_ldx = 0;
    exp_ctrl_t c;
    while (!(use_b ? done_b : done_a) && n < 300) begin
      c = use_b ? cb : ca;
      if (c !== exp_ctrl(n)) bad++;
      if (c.ldt) n_ldt++;
      if (c.ldr) n_ldr++;
      if (c.enc) n_enc++;
      if (c.ldx) n_ldx++;
      tick();
      n++;
    end
    // Edge count includes the edge that sampled start (or release).
    check({tag, "_latency"}, 32'(n + 1), 32'(2 + 3 * terms));
    check({tag, "_pattern"}, 32'(bad), 32'd0);
    check({tag, "_ldt"}, 32'(n_ldt), 32'(2 * terms));
    check({tag, "_ldr"}, 32'(n_ldr), 32'(terms));
    check({tag, "_enc"}, 32'(n_enc), 32'(terms));
    check({tag, "_ldx"}, 32'(n_ldx), 32'd1);
    check({tag, "_done_ctrl"}, 32'(use_b ? cb : ca), 32'd0);
    check({tag, "_done_ready"}, 32'(use_b ? ready_b : ready_a), 32'd1);
  endtask

  initial begin
    int cnt;
    exp_ctrl_t zr_only;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
`ifdef EXP_CTRL_ABORT_EN
    abort_a = 1'b0; abort_b = 1'b0;
`endif
    tick(); tick();
    check("rst_ready_a", 32'(ready_a), 32'd1);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_ctrl_a", 32'(ca), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd1);
    check("rst_ctrl_b", 32'(cb), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check("idle_ready_a", 32'(ready_a), 32'd1);
    check("idle_ctrl_a", 32'(ca), 32'd0);

    // Early carry-out on the 3rd ACC: 3 terms, 11 edges.
    last_a = 2;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("early_ready_drop", 32'(ready_a), 32'd0);
    run_monitor(1'b0, 3, "early");
    cnt = 0;
    repeat (5) begin tick(); if (ldt_a || ldr_a || ldx_a) cnt++; end
    check("early_no_more_loads", 32'(cnt), 32'd0);

    // done held with DONE_PULSE=0 until the next accepted start.
    cnt = 0;
    repeat (100) begin tick(); if (done_a && ready_a) cnt++; end
    check("hold_done_100", 32'(cnt), 32'd100);
    last_a = 15;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("restart_done_fall", 32'(done_a), 32'd0);
    run_monitor(1'b0, 16, "nominal");

    // Synchronous reset while in MUL_C.
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    check("pre_rst_mul_c", 32'(ca), 32'(exp_ctrl(2)));
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    check("midrst_ready", 32'(ready_a), 32'd1);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_ctrl", 32'(ca), 32'd0);
    tick();
    check("midrst_stays_idle", 32'(ca), 32'd0);

`ifdef EXP_CTRL_ABORT_EN
    // Abort in term 7 MUL_X, then a clean full run.
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (19) tick();
    check("abort_pre_mul_x", 32'(ca), 32'(exp_ctrl(19)));
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    zr_only = '0; zr_only.zr = 1'b1;
    check("abort_zr", 32'(ca), 32'(zr_only));
    check("abort_ready", 32'(ready_a), 32'd1);
    check("abort_done", 32'(done_a), 32'd0);
    cnt = 0;
    repeat (60) begin tick(); if (done_a || (ca != '0)) cnt++; end
    check("abort_quiet", 32'(cnt), 32'd0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    run_monitor(1'b0, 16, "post_abort");
`else
    zr_only = '0;
    check("no_abort_zr", 32'(zr_a), 32'(zr_only.zr));
`endif

    // Button mode: no LOAD while start is high; LOAD after release.
    start_b = 1'b1;
    cnt = 0;
    repeat (5) begin tick(); if (ldx_b) cnt++; end
    check("btn_no_load_held", 32'(cnt), 32'd0);
    check("btn_rel_ready", 32'(ready_b), 32'd0);
    start_b = 1'b0; tick();
    run_monitor(1'b1, 16, "button");
    tick();
    check("pulse_done_fall", 32'(done_b), 32'd0);
    check("pulse_ready", 32'(ready_b), 32'd1);
    check("pulse_ctrl", 32'(cb), 32'd0);

    // Start held through the run and DONE: no rerun until release.
    start_b = 1'b1;
    repeat (3) tick();
    start_b = 1'b0; tick();
    start_b = 1'b1;
    run_monitor(1'b1, 16, "btn_held");
    tick();
    check("held_done_fall", 32'(done_b), 32'd0);
    check("held_in_rel", 32'(ready_b), 32'd0);
    cnt = 0;
    repeat (10) begin if (cb != '0) cnt++; tick(); end
    check("held_no_rerun", 32'(cnt), 32'd0);
    start_b = 1'b0; tick();
    check("held_release_load", 32'(cb), 32'(exp_ctrl(0)));
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    check("final_rst_b", 32'(cb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
